// File: rtl/fabric_config_loader_if.sv
// Config word stream, scan chain ports and status flags for fabric_config_loader.
// master = word source / fabric side, slave = the loader.
interface fabric_config_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic              cfg_start;
    logic              cfg_verify_en;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic              conn_scan_in;
    logic              conn_scan_out;
    logic              conn_scan_en;
    logic              clb_scan_in;
    logic              clb_scan_out;
    logic              clb_scan_en;
    logic              busy;
    logic              done;
    logic              error;
    logic              fabric_en;

    modport master (
        output cfg_start, cfg_verify_en, cfg_data, cfg_valid, conn_scan_out, clb_scan_out,
        input  cfg_ready, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en,
        input  busy, done, error, fabric_en
    );

    modport slave (
        input  cfg_start, cfg_verify_en, cfg_data, cfg_valid, conn_scan_out, clb_scan_out,
        output cfg_ready, conn_scan_in, conn_scan_en, clb_scan_in, clb_scan_en,
        output busy, done, error, fabric_en
    );
endinterface

// File: rtl/fabric_config_loader.sv
// Serialises a config word stream into the fabric CONN and CLB scan chains, optionally
// verifies the load by rotating each chain and comparing CRC-16-CCITT signatures.
module fabric_config_loader #(
    parameter int unsigned FPGA_WIDTH     = 2,
    parameter int unsigned CONN_CHAIN_LEN = 64,
    parameter int unsigned CLB_CHAIN_LEN  = 32,
    parameter int unsigned WORD_W         = 8
) (
    input logic                   clk,
    input logic                   rst,
    fabric_config_loader_if.slave bus
);
    localparam int unsigned MAX_LEN =
        (CONN_CHAIN_LEN > CLB_CHAIN_LEN) ? CONN_CHAIN_LEN : CLB_CHAIN_LEN;
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    localparam int unsigned BL_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CONN_LEN = CNT_W'(CONN_CHAIN_LEN);
    localparam logic [CNT_W-1:0] CLB_LEN  = CNT_W'(CLB_CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_W);

    // Fabric size is informational only; the chain lengths drive all sizing.
    if (FPGA_WIDTH == 0) begin : g_no_tiles
    end

    typedef enum logic [2:0] {
        StIdle, StLoadConn, StLoadClb, StVerifyConn, StVerifyClb, StFin
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [BL_W-1:0]   bits_left_q, bits_left_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       crc_q, crc_d;
    logic [15:0]       crc_ref_q, crc_ref_d;
    logic              verify_en_q, verify_en_d;
    logic              error_q, error_d;
    logic              fabric_en_q, fabric_en_d;

    logic             is_conn, is_load, is_verify, shifting, scan_bit, last_bit, accept;
    logic [CNT_W-1:0] len, remain, take;
    logic [15:0]      crc_next;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        is_conn   = (state_q == StLoadConn) || (state_q == StVerifyConn);
        is_load   = (state_q == StLoadConn) || (state_q == StLoadClb);
        is_verify = (state_q == StVerifyConn) || (state_q == StVerifyClb);
        len       = is_conn ? CONN_LEN : CLB_LEN;
        remain    = len - acc_q;
        take      = (remain < WORD_LEN) ? remain : WORD_LEN;
        shifting  = (is_load && (bits_left_q != '0)) || is_verify;
        // Verify rotates the chain tail back into its head.
        scan_bit  = is_load ? buf_q[0] : (is_conn ? bus.conn_scan_out : bus.clb_scan_out);
        crc_next  = crc16_step(crc_q, scan_bit);
        last_bit  = shifting && (cnt_q == len - 1'b1);
        accept    = bus.cfg_valid && bus.cfg_ready;
    end

    assign bus.cfg_ready    = is_load && (bits_left_q <= BL_W'(1)) && (acc_q < len);
    assign bus.conn_scan_en = shifting && is_conn;
    assign bus.conn_scan_in = shifting && is_conn && scan_bit;
    assign bus.clb_scan_en  = shifting && !is_conn;
    assign bus.clb_scan_in  = shifting && !is_conn && scan_bit;
    assign bus.busy         = (state_q != StIdle);
    assign bus.done         = (state_q == StFin);
    assign bus.error        = error_q;
    assign bus.fabric_en    = fabric_en_q;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        bits_left_d = bits_left_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        crc_ref_d   = crc_ref_q;
        verify_en_d = verify_en_q;
        error_d     = error_q;
        fabric_en_d = fabric_en_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_start) begin
                    state_d     = StLoadConn;
                    error_d     = 1'b0;
                    fabric_en_d = 1'b0;
                    crc_d       = 16'hFFFF;
                    verify_en_d = bus.cfg_verify_en;
                    bits_left_d = '0;
                    acc_d       = '0;
                    cnt_d       = '0;
                end
            end
            StLoadConn, StLoadClb: begin
                if (shifting) begin
                    buf_d       = buf_q >> 1;
                    bits_left_d = bits_left_q - 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    crc_d       = crc_next;
                end
                // Accepting while the last bit shifts keeps the stream gapless.
                if (accept) begin
                    buf_d       = bus.cfg_data;
                    bits_left_d = BL_W'(take);
                    acc_d       = acc_q + take;
                end
                if (last_bit) begin
                    cnt_d = '0;
                    acc_d = '0;
                    if (state_q == StLoadConn) begin
                        state_d = StLoadClb;
                    end else begin
                        crc_ref_d = crc_next;
                        crc_d     = 16'hFFFF;
                        if (verify_en_q) begin
                            state_d = StVerifyConn;
                        end else begin
                            state_d     = StFin;
                            fabric_en_d = 1'b1;
                        end
                    end
                end
            end
            StVerifyConn, StVerifyClb: begin
                cnt_d = cnt_q + 1'b1;
                crc_d = crc_next;
                if (last_bit) begin
                    cnt_d = '0;
                    if (state_q == StVerifyConn) begin
                        state_d = StVerifyClb;
                    end else begin
                        state_d = StFin;
                        if (crc_next != crc_ref_q) error_d = 1'b1;
                        else fabric_en_d = 1'b1;
                    end
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            bits_left_q <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            crc_q       <= 16'hFFFF;
            crc_ref_q   <= '0;
            verify_en_q <= 1'b0;
            error_q     <= 1'b0;
            fabric_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            bits_left_q <= bits_left_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            crc_ref_q   <= crc_ref_d;
            verify_en_q <= verify_en_d;
            error_q     <= error_d;
            fabric_en_q <= fabric_en_d;
        end
    end
endmodule
